nested_sum_fsm: RTL and testbench
=================================

// Module: nested_sum_fsm
// PURPOSE
//  Parametrised nested-loop accumulator for the arithmetic property-mining cases.
//  Outer loop walks i from I_INIT up to I_MAX-1; inner loop walks j=0..i-1 adding (i-j) to k.
//  Adds over the fixed-width predecessor: generic width and bounds, step enable, restart
//  without reset, and explicit done/halt flags. Observable state (turn,k,i,j) feeds the miner.
// PARAMETERS
//  W       11    width of k, i, j (unsigned)
//  I_MAX   60    outer-loop bound; turn->DONE when i >= I_MAX in CHECK
//  K_CAP   2000  freeze bound; no update of any state while k >= K_CAP
//  K_INIT  1     reset/restart value of k
//  I_INIT  1     reset/restart value of i
// PORTS
//  clk      in   1  clock, rising edge
//  rst      in   1  synchronous, active-high reset
//  en       in   1  step enable; 0 holds all state
//  restart  in   1  synchronous re-initialise (same values as reset)
//  turn     out  3  state: 0 CHECK, 1 INNER, 2 INC, 3 DONE
//  k        out  W  accumulator
//  i        out  W  outer index
//  j        out  W  inner index
//  done     out  1  registered, 1 while turn==3
//  halted   out  1  registered, 1 while k >= K_CAP (freeze)
//  ovf      out  1  sticky saturation flag (see CONFIGURATION)
// BEHAVIOUR
//  - One clock, synchronous active-high reset. Priority: rst > restart > en.
//  - Reset/restart: turn=0, k=K_INIT, i=I_INIT, j=0, done=0, halted=(K_INIT>=K_CAP), ovf=0.
//  - Update only when en=1 and k < K_CAP; otherwise all regs hold (freeze has no exit but rst/restart).
//  - CHECK(0): j<=0; i<I_MAX -> INNER, else -> DONE. k,i unchanged.
//  - INNER(1): j<i -> k<=k+(i-j), j<=j+1, stay; j>=i -> INNER->INC, nothing else changes.
//  - INC(2): i<=i+1 -> CHECK. DONE(3): absorbing; holds all state.
//  - Illegal turn (4..7): hold all state (no recovery except rst/restart).
//  - i-j never negative (j<i guarded); all compares unsigned, W bits.
//  - One transition per enabled cycle; outputs are the registers themselves (0 latency).
//  - done/halted are registered from next-state values, so they assert in the same cycle
//    as the turn/k update that causes them.
//  - restart mid-INNER or during freeze: re-initialise next edge, ovf cleared.
//  - Analytic: after outer iteration i completes, k = K_INIT + i(i+1)(i+2)/6 (defaults).
// CONFIGURATION
//  NESTED_SUM_SAT_EN defined: k+(i-j) computed in W+1 bits; if > 2^W-1, k<=2^W-1 and ovf<=1
//  (sticky until rst/restart).
//  Not defined: k wraps modulo 2^W; ovf tied 0.
// TESTING
//  1 defaults, en=1 from reset -> freezes at turn=1, i=22, j=16, k=2004, halted=1; holds 20+ cycles.
//  2 I_MAX=4, K_CAP=2000 -> turn=3, i=4, j=3, k=11, done=1; state stable thereafter.
//  3 defaults, en toggled 0/1 randomly -> identical final state to test 1; no change on en=0 cycles.
//  4 restart pulsed mid-INNER (i=5,j=2) -> next cycle turn=0,k=1,i=1,j=0; rst+restart together -> reset values.
//  5 W=6, K_CAP=63, NESTED_SUM_SAT_EN -> k clamps 63, ovf=1; without macro -> k wraps, ovf=0.
//  6 every cycle check: turn<=3, j<=i, (turn!=3)||(k>=I_MAX); with defaults, k>=K_CAP never with done=1.

Source files
------------

// File: rtl/nested_sum_fsm.sv
// Nested-loop accumulator FSM: for i in [I_INIT, I_MAX) and j in [0, i), k += (i-j).
// Optional macro NESTED_SUM_SAT_EN: saturate k at 2^W-1 and set sticky ovf; otherwise k wraps.
module nested_sum_fsm #(
  parameter int unsigned W      = 11,
  parameter int unsigned I_MAX  = 60,
  parameter int unsigned K_CAP  = 2000,
  parameter int unsigned K_INIT = 1,
  parameter int unsigned I_INIT = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic         restart_i,
  output logic [2:0]   turn_o,
  output logic [W-1:0] k_o,
  output logic [W-1:0] i_o,
  output logic [W-1:0] j_o,
  output logic         done_o,
  output logic         halted_o,
  output logic         ovf_o
);

  localparam logic [2:0] S_CHECK = 3'd0;
  localparam logic [2:0] S_INNER = 3'd1;
  localparam logic [2:0] S_INC   = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;

  localparam logic [W-1:0] K_INIT_W = W'(K_INIT);
  localparam logic [W-1:0] I_INIT_W = W'(I_INIT);
  localparam logic [W:0]   K_CAP_X  = (W+1)'(K_CAP);
  localparam logic [W:0]   I_MAX_X  = (W+1)'(I_MAX);
  localparam logic         HALT_INIT = ({1'b0, K_INIT_W} >= K_CAP_X);

  logic [2:0]   turn_q, turn_d;
  logic [W-1:0] k_q, k_d;
  logic [W-1:0] i_q, i_d;
  logic [W-1:0] j_q, j_d;
  logic         done_q, done_d;
  logic         halted_q, halted_d;
  logic         ovf_q, ovf_d;

  logic [W-1:0] diff;
  logic [W-1:0] k_add;
  logic         add_ovf;
  logic         frozen;
  logic         step;

  // Only consumed when j < i, so the subtraction never underflows.
  assign diff = i_q - j_q;

`ifdef NESTED_SUM_SAT_EN
  logic [W:0] sum_wide;
  assign sum_wide = {1'b0, k_q} + {1'b0, diff};
  assign k_add    = sum_wide[W] ? {W{1'b1}} : sum_wide[W-1:0];
  assign add_ovf  = sum_wide[W];
`else
  assign k_add    = k_q + diff;
  assign add_ovf  = 1'b0;
`endif

  assign frozen = ({1'b0, k_q} >= K_CAP_X);
  assign step   = en_i && !frozen;

  always_comb begin
    turn_d = turn_q;
    k_d    = k_q;
    i_d    = i_q;
    j_d    = j_q;
    ovf_d  = ovf_q;
    if (step) begin
      case (turn_q)
        S_CHECK: begin
          // j is cleared only on entry to INNER; DONE keeps the last inner index visible.
          if ({1'b0, i_q} < I_MAX_X) begin
            turn_d = S_INNER;
            j_d    = '0;
          end else begin
            turn_d = S_DONE;
          end
        end
        S_INNER: begin
          if (j_q < i_q) begin
            k_d   = k_add;
            j_d   = j_q + W'(1);
            ovf_d = ovf_q | add_ovf;
          end else begin
            turn_d = S_INC;
          end
        end
        S_INC: begin
          i_d    = i_q + W'(1);
          turn_d = S_CHECK;
        end
        default: ;
      endcase
    end
    done_d   = (turn_d == S_DONE);
    halted_d = ({1'b0, k_d} >= K_CAP_X);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || restart_i) begin
      turn_q   <= S_CHECK;
      k_q      <= K_INIT_W;
      i_q      <= I_INIT_W;
      j_q      <= '0;
      done_q   <= 1'b0;
      halted_q <= HALT_INIT;
      ovf_q    <= 1'b0;
    end else begin
      turn_q   <= turn_d;
      k_q      <= k_d;
      i_q      <= i_d;
      j_q      <= j_d;
      done_q   <= done_d;
      halted_q <= halted_d;
      ovf_q    <= ovf_d;
    end
  end

  assign turn_o   = turn_q;
  assign k_o      = k_q;
  assign i_o      = i_q;
  assign j_o      = j_q;
  assign done_o   = done_q;
  assign halted_o = halted_q;
  assign ovf_o    = ovf_q;

endmodule

// File: tb/tb_nested_sum_fsm.sv
// Scoreboard bench: three configurations of nested_sum_fsm driven by shared random en/restart/rst,
// compared each cycle against a precomputed trace of the nested loop.
module tb_nested_sum_fsm;

  typedef struct packed {
    int turn; int k; int i; int j; int done; int halted; int ovf;
  } st_t;

`ifdef NESTED_SUM_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1, restart = 1'b0, en = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  turnA, turnB, turnC;
  logic [10:0] kA, iA, jA, kB, iB, jB;
  logic [5:0]  kC, iC, jC;
  logic doneA, haltA, ovfA, doneB, haltB, ovfB, doneC, haltC, ovfC;

  nested_sum_fsm u_a (
    .clk_i(clk), .rst_i(rst), .en_i(en), .restart_i(restart),
    .turn_o(turnA), .k_o(kA), .i_o(iA), .j_o(jA), .done_o(doneA), .halted_o(haltA), .ovf_o(ovfA));

  nested_sum_fsm #(.I_MAX(4)) u_b (
    .clk_i(clk), .rst_i(rst), .en_i(en), .restart_i(restart),
    .turn_o(turnB), .k_o(kB), .i_o(iB), .j_o(jB), .done_o(doneB), .halted_o(haltB), .ovf_o(ovfB));

  nested_sum_fsm #(.W(6), .K_CAP(63)) u_c (
    .clk_i(clk), .rst_i(rst), .en_i(en), .restart_i(restart),
    .turn_o(turnC), .k_o(kC), .i_o(iC), .j_o(jC), .done_o(doneC), .halted_o(haltC), .ovf_o(ovfC));

  st_t tr[3][$];
  st_t expq[3][$];
  int  p[3];
  int  imax_of[3] = '{60, 4, 60};
  int  checks = 0, errors = 0;

  function automatic void push_st(int id, int turn, int k, int i, int j, int ovf, int kcap);
    st_t s;
    s.turn = turn; s.k = k; s.i = i; s.j = j; s.ovf = ovf;
    s.done = (turn == 3) ? 1 : 0;
    s.halted = (k >= kcap) ? 1 : 0;
    tr[id].push_back(s);
  endfunction

  // Sequence of states visited, one per enabled step; the last entry is DONE or the frozen state.
  function automatic void build(int id, int w, int imax, int kcap, int kinit, int iinit);
    int mask, k, i, j, ovf;
    mask = (1 << w) - 1;
    k = kinit; i = iinit; j = 0; ovf = 0;
    push_st(id, 0, k, i, j, ovf, kcap);
    while (tr[id].size() < 20000) begin
      if (k >= kcap) return;
      if (i >= imax) begin push_st(id, 3, k, i, j, ovf, kcap); return; end
      j = 0;
      push_st(id, 1, k, i, j, ovf, kcap);
      while (j < i) begin
        if (k >= kcap) return;
        if (SAT && (k + (i - j) > mask)) begin k = mask; ovf = 1; end
        else k = (k + (i - j)) & mask;
        j++;
        push_st(id, 1, k, i, j, ovf, kcap);
      end
      if (k >= kcap) return;
      push_st(id, 2, k, i, j, ovf, kcap);
      i = (i + 1) & mask;
      push_st(id, 0, k, i, j, ovf, kcap);
    end
  endfunction

  function automatic st_t snap(int id);
    st_t s;
    case (id)
      0: begin s.turn = int'(turnA); s.k = int'(kA); s.i = int'(iA); s.j = int'(jA);
               s.done = int'(doneA); s.halted = int'(haltA); s.ovf = int'(ovfA); end
      1: begin s.turn = int'(turnB); s.k = int'(kB); s.i = int'(iB); s.j = int'(jB);
               s.done = int'(doneB); s.halted = int'(haltB); s.ovf = int'(ovfB); end
      default: begin s.turn = int'(turnC); s.k = int'(kC); s.i = int'(iC); s.j = int'(jC);
               s.done = int'(doneC); s.halted = int'(haltC); s.ovf = int'(ovfC); end
    endcase
    return s;
  endfunction

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cmp(int id, st_t a, st_t e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL sb[%0d] t=%0t: got turn=%0d k=%0d i=%0d j=%0d done=%0d halted=%0d ovf=%0d expected turn=%0d k=%0d i=%0d j=%0d done=%0d halted=%0d ovf=%0d",
               id, $time, a.turn, a.k, a.i, a.j, a.done, a.halted, a.ovf,
               e.turn, e.k, e.i, e.j, e.done, e.halted, e.ovf);
    end
  endtask

  // Inputs change on the falling edge; the expected post-edge state is queued at the same time.
  task automatic drive(bit r, bit rs, bit e);
    @(negedge clk);
    rst = r; restart = rs; en = e;
    for (int id = 0; id < 3; id++) begin
      if (r || rs) p[id] = 0;
      else if (e && p[id] < tr[id].size() - 1) p[id]++;
      expq[id].push_back(tr[id][p[id]]);
    end
  endtask

  // Monitor: pops and compares shortly after each rising edge.
  initial begin
    st_t a;
    forever begin
      @(posedge clk);
      #2;
      for (int id = 0; id < 3; id++) begin
        if (expq[id].size() != 0) begin
          a = snap(id);
          cmp(id, a, expq[id].pop_front());
          if (id < 2) begin
            chk($sformatf("inv_turn[%0d]", id), int'(a.turn <= 3), 1);
            chk($sformatf("inv_j_le_i[%0d]", id), int'(a.j <= a.i), 1);
            chk($sformatf("inv_done_k[%0d]", id), int'(a.turn != 3 || a.k >= imax_of[id]), 1);
          end
          if (id == 0) chk("inv_not_done_and_halted", int'(a.done != 0 && a.halted != 0), 0);
        end
      end
    end
  end

  task automatic sample_after_edge();
    @(posedge clk);
    #3;
  endtask

  initial begin
    st_t s;
    build(0, 11, 60, 2000, 1, 1);
    build(1, 11, 4, 2000, 1, 1);
    build(2, 6, 60, 63, 1, 1);
    p = '{0, 0, 0};

    drive(1, 0, 0);
    drive(1, 0, 1);
    sample_after_edge();
    chk("reset_turn", int'(turnA), 0);
    chk("reset_k", int'(kA), 1);
    chk("reset_i", int'(iA), 1);
    chk("reset_j", int'(jA), 0);
    chk("reset_halted", int'(haltA), 0);

    // Continuous enable: A freezes, B finishes.
    for (int n = 0; n < 400; n++) drive(0, 0, 1);
    sample_after_edge();
    chk("freeze_turn", int'(turnA), 1);
    chk("freeze_i", int'(iA), 22);
    chk("freeze_j", int'(jA), 16);
    chk("freeze_k", int'(kA), 2004);
    chk("freeze_halted", int'(haltA), 1);
    chk("imax4_turn", int'(turnB), 3);
    chk("imax4_i", int'(iB), 4);
    chk("imax4_j", int'(jB), 3);
    chk("imax4_k", int'(kB), 11);
    chk("imax4_done", int'(doneB), 1);

    // Restart out of freeze, then restart again mid-INNER at i=5, j=2.
    drive(0, 1, 0);
    for (int n = 0; n < 200; n++) begin
      s = tr[0][p[0]];
      if (s.turn == 1 && s.i == 5 && s.j == 2) break;
      drive(0, 0, 1);
    end
    s = tr[0][p[0]];
    chk("reached_i5_j2", int'(s.turn == 1 && s.i == 5 && s.j == 2), 1);
    drive(0, 1, 1);
    sample_after_edge();
    chk("restart_turn", int'(turnA), 0);
    chk("restart_k", int'(kA), 1);
    chk("restart_i", int'(iA), 1);
    chk("restart_j", int'(jA), 0);

    for (int n = 0; n < 1200; n++)
      drive(0, ($urandom_range(299) == 0), bit'($urandom_range(1)));

    drive(1, 1, 1);
    sample_after_edge();
    chk("rst_restart_k", int'(kA), 1);
    chk("rst_restart_turn", int'(turnA), 0);
    chk("rst_restart_ovf", int'(ovfC), 0);

    // Random enable to completion: same final state as the continuous run.
    for (int n = 0; n < 3500; n++)
      drive(0, 0, ($urandom_range(9) < 7));
    sample_after_edge();
    chk("rand_en_turn", int'(turnA), 1);
    chk("rand_en_i", int'(iA), 22);
    chk("rand_en_j", int'(jA), 16);
    chk("rand_en_k", int'(kA), 2004);
    if (SAT) begin
      chk("sat_k", int'(kC), 63);
      chk("sat_ovf", int'(ovfC), 1);
    end else begin
      chk("wrap_ovf", int'(ovfC), 0);
    end

    repeat (3) @(posedge clk);
    #2;
    for (int id = 0; id < 3; id++) chk($sformatf("sb_drained[%0d]", id), expq[id].size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
